// File: rtl/corr_mult_sched.sv
// ----------------------------------------------------------------------------
// corr_mult_sched
//
// Purpose:
//    Shares one pipelined 5x13 signed multiplier (DSP product tile, P = A*B)
//    among NUM_REQ correlator lane controllers. A round-robin arbiter picks
//    one requester per cycle. The requester ID travels alongside the
//    multiplier pipeline in a tag shift register. Each finished product is
//    written into a show-ahead result FIFO. Operations are issued only when
//    enough result space is guaranteed, so downstream back-pressure never
//    drops a product.
//
// Ports:
//    clk         clock
//    reset       asynchronous assert, active-high
//    req_valid   [NUM_REQ]      per-requester operand valid
//    req_a       [5*NUM_REQ]    signed 5-bit operand A, requester i at [5i+4:5i]
//    req_b       [13*NUM_REQ]   signed 13-bit operand B, requester i at [13i+12:13i]
//    req_ready   [NUM_REQ]      one-hot grant; accept = req_valid[i] & req_ready[i]
//    mult_a      [5]            registered operand A to the multiplier
//    mult_b      [13]           registered operand B to the multiplier
//    mult_p      [48]           multiplier product (only bits 17:0 are used)
//    res_valid                  result FIFO head is valid
//    res_id      [ID_W]         requester ID of the head result
//    res_p       [18]           signed head product
//    res_ready                  downstream accept; pop = res_valid & res_ready
//
// Optional feature (macro CORR_SCHED_STATS_EN):
//    stat_issued [32]           number of accepted operations (wraps)
//    stat_stall  [32]           cycles with any req_valid but no credit (wraps)
//
// Timing, with the accept at edge E0:
//    E0            mult_a/mult_b and tag stage 0 load
//    E0+MULT_LAT-1 mult_p holds the product and the last tag stage its ID
//    E0+MULT_LAT   product and ID captured
//    E0+MULT_LAT+1 captured entry written into the FIFO storage
//    E0+MULT_LAT+2 entry loaded into the head registers, res_valid rises
// ----------------------------------------------------------------------------
module corr_mult_sched #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int MULT_LAT   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [5*NUM_REQ-1:0]   req_a,
   input  logic [13*NUM_REQ-1:0]  req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [4:0]             mult_a,
   output logic [12:0]            mult_b,
   input  logic [47:0]            mult_p,
   output logic                   res_valid,
   output logic [ID_W-1:0]        res_id,
   output logic [17:0]            res_p,
   input  logic                   res_ready
`ifdef CORR_SCHED_STATS_EN
   ,
   output logic [31:0]            stat_issued,
   output logic [31:0]            stat_stall
`endif
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   // Wide enough for FIFO occupancy plus every in-flight slot.
   localparam int CNT_W   = $clog2(FIFO_DEPTH + MULT_LAT + 2) + 1;
   localparam int ENTRY_W = ID_W + 18;

   // ------------------------------------------------------------------------
   // Operand unpacking
   // ------------------------------------------------------------------------
   logic [4:0]  a_arr [NUM_REQ];
   logic [12:0] b_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[5*gi +: 5];
         assign b_arr[gi] = req_b[13*gi +: 13];
      end
   endgenerate

   // The product of a 5x13 signed multiply fits in 18 bits.
   logic p_upper_unused;
   assign p_upper_unused = ^mult_p[47:18];

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ID_W-1:0]    rr_ptr;

   logic               tag_vld [MULT_LAT];
   logic [ID_W-1:0]    tag_id  [MULT_LAT];

   logic               cap_vld;
   logic [ID_W-1:0]    cap_id;
   logic [17:0]        cap_p;

   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     mem_count;

   // ------------------------------------------------------------------------
   // Credit: count everything that will eventually occupy a result slot.
   // That is the stored entries, the head register, the capture register and
   // every valid tag stage.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] occupancy;
   logic             credit_ok;

   always_comb begin
      inflight = CNT_W'(cap_vld);
      for (int k = 0; k < MULT_LAT; k++) begin
         inflight = inflight + CNT_W'(tag_vld[k]);
      end
   end

   assign occupancy = CNT_W'(mem_count) + CNT_W'(res_valid);
   assign credit_ok = (occupancy + inflight) < CNT_W'(FIFO_DEPTH);

   // ------------------------------------------------------------------------
   // Round-robin arbiter: first valid requester at or above rr_ptr, with wrap
   // ------------------------------------------------------------------------
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic [ID_W-1:0] scan_idx;
   int              scan;
   logic            accept;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = 0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NUM_REQ) begin
            scan = scan - NUM_REQ;
         end
         scan_idx = ID_W'(scan);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Gate the grant during reset so nothing is accepted while the block is
   // being cleared.
   always_comb begin
      req_ready = '0;
      if (grant_found && credit_ok && !reset) begin
         req_ready = NUM_REQ'(1) << grant_idx;
      end
   end

   assign accept = grant_found && credit_ok;

   // ------------------------------------------------------------------------
   // Issue: operands and tag stage 0
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         mult_a     <= '0;
         mult_b     <= '0;
         tag_vld[0] <= 1'b0;
         tag_id[0]  <= '0;
      end else begin
         tag_vld[0] <= accept;
         if (accept) begin
            // Operands hold when idle so the multiplier inputs do not toggle.
            mult_a    <= a_arr[grant_idx];
            mult_b    <= b_arr[grant_idx];
            tag_id[0] <= grant_idx;
            rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + ID_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipe: stage k holds the ID of the operation issued k+1 edges ago, so
   // the last stage lines up with mult_p.
   // ------------------------------------------------------------------------
   generate
      for (gi = 1; gi < MULT_LAT; gi++) begin : g_tag
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               tag_vld[gi] <= 1'b0;
               tag_id[gi]  <= '0;
            end else begin
               tag_vld[gi] <= tag_vld[gi-1];
               tag_id[gi]  <= tag_id[gi-1];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Capture of the product with its ID
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_vld <= 1'b0;
         cap_id  <= '0;
         cap_p   <= '0;
      end else begin
         cap_vld <= tag_vld[MULT_LAT-1];
         cap_id  <= tag_id[MULT_LAT-1];
         cap_p   <= mult_p[17:0];
      end
   end

   // ------------------------------------------------------------------------
   // Result FIFO: RAM storage plus a registered head. The head refills
   // whenever it is empty or being popped and the storage holds data.
   // ------------------------------------------------------------------------
   logic push;
   logic pop;
   logic head_load;

   assign push      = cap_vld;
   assign pop       = res_valid && res_ready;
   assign head_load = (!res_valid || pop) && (mem_count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cap_id, cap_p};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_p     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end

         if (head_load) begin
            {res_id, res_p} <= fifo_mem[rd_ptr];
            res_valid       <= 1'b1;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end else if (pop) begin
            res_valid <= 1'b0;
         end

         case ({push, head_load})
            2'b10:   mem_count <= mem_count + (PTR_W+1)'(1);
            2'b01:   mem_count <= mem_count - (PTR_W+1)'(1);
            default: mem_count <= mem_count;
         endcase
      end
   end

`ifdef CORR_SCHED_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics counters (free-running, wrap at 2^32)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (accept) begin
            stat_issued <= stat_issued + 32'd1;
         end
         if ((|req_valid) && !credit_ok) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_corr_mult_sched.sv
// ----------------------------------------------------------------------------
// tb_corr_mult_sched
//
// Directed bench for corr_mult_sched. A behavioural multiplier stands in for
// the DSP tile. mult_p shows the product of mult_a/mult_b MULT_LAT-1 edges
// after the operand register loads, which gives a total of MULT_LAT registers
// from the operand register to P. Results popped by the DUT are logged at the
// falling edge and compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_corr_mult_sched;

   localparam int NUM_REQ    = 4;
   localparam int ID_W       = 2;
   localparam int MULT_LAT   = 4;
   localparam int FIFO_DEPTH = 8;

   logic                  clk;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [5*NUM_REQ-1:0]  req_a;
   logic [13*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic [4:0]            mult_a;
   logic [12:0]           mult_b;
   logic [47:0]           mult_p;
   logic                  res_valid;
   logic [ID_W-1:0]       res_id;
   logic [17:0]           res_p;
   logic                  res_ready;

   corr_mult_sched #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W),
      .MULT_LAT   (MULT_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .mult_p    (mult_p),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_p     (res_p),
      .res_ready (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: three register stages after the DUT operand register.
   // It is never reset, as with a DSP whose pipeline keeps running.
   logic signed [47:0] p1 = '0;
   logic signed [47:0] p2 = '0;
   logic signed [47:0] p3 = '0;
   always @(posedge clk) begin
      p1 <= 48'($signed(mult_a) * $signed(mult_b));
      p2 <= p1;
      p3 <= p2;
   end
   assign mult_p = p3;

   // Falling-edge log of popped results and of accepted requests.
   logic [ID_W-1:0] rid_q [$];
   logic [17:0]     rp_q  [$];
   int              acc_cnt = 0;
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         rid_q.push_back(res_id);
         rp_q.push_back(res_p);
      end
      if (!reset && ((req_valid & req_ready) != '0)) begin
         acc_cnt = acc_cnt + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v,
                          input logic signed [4:0] a, input logic signed [12:0] b);
      req_valid[i]     = v;
      req_a[5*i +: 5]   = a;
      req_b[13*i +: 13] = b;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_res(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (rid_q.size() < target && n < budget) begin
         step();
         n++;
      end
      check(tag, 64'(rid_q.size()), 64'(target));
   endtask

   // Operands of scenarios 2 and 3 and their hand-computed products.
   logic signed [4:0]  op_a  [NUM_REQ];
   logic signed [12:0] op_b  [NUM_REQ];
   logic [17:0]        exp_p [NUM_REQ];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int acc_base;

      op_a[0] = 5'sd1;   op_b[0] = 13'sd10;   exp_p[0] = 18'd10;
      op_a[1] = 5'sd2;   op_b[1] = -13'sd20;  exp_p[1] = 18'(-40);
      op_a[2] = -5'sd3;  op_b[2] = 13'sd30;   exp_p[2] = 18'(-90);
      op_a[3] = 5'sd4;   op_b[3] = -13'sd40;  exp_p[3] = 18'(-160);

      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;

      // ---- Reset state, with every requester valid ----
      step();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, op_a[i], op_b[i]);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_mult_a",    64'(mult_a),    64'd0);
      check("rst_mult_b",    64'(mult_b),    64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_id",    64'(res_id),    64'd0);
      check("rst_res_p",     64'(res_p),     64'd0);
      req_valid = '0;
      reset = 1'b0;
      step();

      // ---- 1: single op, req0 a=-3 b=100 ----
      set_req(0, 1'b1, -5'sd3, 13'sd100);
      #1;
      check("t1_grant", 64'(req_ready), 64'b0001);
      step();
      set_req(0, 1'b0, 5'sd0, 13'sd0);
      check("t1_mult_a", 64'(mult_a), 64'h1D);
      check("t1_mult_b", 64'(mult_b), 64'd100);
      for (int i = 1; i <= 5; i++) begin
         step();
         check("t1_latency_low", 64'(res_valid), 64'd0);
      end
      step();
      check("t1_valid", 64'(res_valid), 64'd1);
      check("t1_id",    64'(res_id),    64'd0);
      check("t1_p",     64'(res_p),     64'h3FED4);
      step();
      check("t1_popped", 64'(res_valid), 64'd0);

      // ---- 2: all requesters valid, res_ready=1 ----
      do_reset();
      base     = rid_q.size();
      acc_base = acc_cnt;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, op_a[i], op_b[i]);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t2_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         step();
      end
      req_valid = '0;
      check("t2_accepts", 64'(acc_cnt - acc_base), 64'd8);
      wait_res(base + 8, 30, "t2_result_count");
      for (int k = 0; k < 8; k++) begin
         if (base + k < rid_q.size()) begin
            check("t2_id", 64'(rid_q[base+k]), 64'(k % 4));
            check("t2_p",  64'(rp_q[base+k]),  64'(exp_p[k % 4]));
         end
      end

      // ---- 3: back-pressure, credit limit and resume ----
      do_reset();
      base      = rid_q.size();
      acc_base  = acc_cnt;
      res_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, op_a[i], op_b[i]);
      repeat (14) step();
      check("t3_accepts_full", 64'(acc_cnt - acc_base), 64'd8);
      #1;
      check("t3_no_grant", 64'(req_ready), 64'd0);
      check("t3_head_valid", 64'(res_valid), 64'd1);
      res_ready = 1'b1;
      #1;
      check("t3_hold_before_pop", 64'(req_ready), 64'd0);
      step();
      #1;
      check("t3_resume_grant", 64'(req_ready), 64'b0001);
      step();
      req_valid = '0;
      check("t3_accepts_total", 64'(acc_cnt - acc_base), 64'd9);
      wait_res(base + 9, 40, "t3_result_count");
      for (int k = 0; k < 9; k++) begin
         if (base + k < rid_q.size()) begin
            check("t3_id", 64'(rid_q[base+k]), 64'(k % 4));
            check("t3_p",  64'(rp_q[base+k]),  64'(exp_p[k % 4]));
         end
      end

      // ---- 4: operand extremes ----
      do_reset();
      base = rid_q.size();
      set_req(1, 1'b1, -5'sd16, -13'sd4096);
      #1;
      check("t4_grant1", 64'(req_ready), 64'b0010);
      step();
      set_req(1, 1'b0, 5'sd0, 13'sd0);
      set_req(2, 1'b1, 5'sd15, -13'sd4096);
      #1;
      check("t4_grant2", 64'(req_ready), 64'b0100);
      step();
      req_valid = '0;
      wait_res(base + 2, 20, "t4_result_count");
      if (base + 1 < rid_q.size()) begin
         check("t4_id_max", 64'(rid_q[base]),   64'd1);
         check("t4_p_max",  64'(rp_q[base]),    64'h10000);
         check("t4_id_min", 64'(rid_q[base+1]), 64'd2);
         check("t4_p_min",  64'(rp_q[base+1]),  64'h31000);
      end

      // ---- 5: reset with ops in flight ----
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, op_a[i], op_b[i]);
      repeat (3) step();
      req_valid = '0;
      step();
      reset = 1'b1;
      #1;
      check("t5_rst_ready", 64'(req_ready), 64'd0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5_quiet", 64'(res_valid), 64'd0);
      end
      set_req(3, 1'b1, 5'sd7, -13'sd1000);
      #1;
      check("t5_grant", 64'(req_ready), 64'b1000);
      step();
      req_valid = '0;
      repeat (5) step();
      check("t5_latency_low", 64'(res_valid), 64'd0);
      step();
      check("t5_valid", 64'(res_valid), 64'd1);
      check("t5_id",    64'(res_id),    64'd3);
      check("t5_p",     64'(res_p),     64'h3E4A8);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
